// File: rtl/al422_writer_if.sv
// Byte-stream handshake into the AL422 writer: the host drives data, sof and
// valid, and the writer drives ready.
interface al422_writer_if;
   logic [7:0] s_data;
   logic       s_sof;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_sof, output s_valid, input s_ready);
   modport slave  (input s_data, input s_sof, input s_valid, output s_ready);
endinterface

// File: rtl/al422_writer.sv
// AL422 FIFO frame writer.
// Each frame starts with a /WRST pulse that lasts WRST_WCK write-clock
// periods. The bytes of the frame are then written at up to one byte per two
// in_clk cycles. Every pin to the AL422 is driven straight from a flop.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | between frames; accepts only a sof byte, drops anything else
// RST_LO  | /WRST low, WCK low half of a pointer-reset period
// RST_HI  | /WRST low, WCK high half of a pointer-reset period
// WR_HOLD | presents the stored sof byte with /WE low, WCK low
// LO      | WCK low, ready for the next byte of the frame
// HI      | WCK high; the AL422 latches the byte; frame counter advances
module al422_writer #(
   parameter int FRAME_BYTES = 256,
   parameter int WRST_WCK    = 4
) (
   input  logic          in_clk,
   input  logic          in_rst,
   al422_writer_if.slave s_if,
   output logic [7:0]    al422_data,
   output logic          al422_wck,
   output logic          al422_nwe,
   output logic          al422_nwrst,
   output logic          frame_done,
   output logic          err_short,
   output logic          err_drop
);

   localparam int CNT_W = $clog2(FRAME_BYTES + 1);

   typedef enum logic [2:0] {IDLE, RST_LO, RST_HI, WR_HOLD, LO, HI} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       rst_cnt_q, rst_cnt_d;
   logic [7:0]       hold_q, hold_d;
   logic [7:0]       data_q, data_d;
   logic             s_ready_q, s_ready_d;
   logic             wck_q, wck_d;
   logic             nwe_q, nwe_d;
   logic             nwrst_q, nwrst_d;
   logic             frame_done_q, frame_done_d;
   logic             err_short_q, err_short_d;
   logic             err_drop_q, err_drop_d;
   logic             xfer;

   // The handshake uses the registered ready, so it never depends on s_valid.
   assign xfer = s_ready_q & s_if.s_valid;

   // Next state, counters and data path. The pin levels are decoded from the
   // state that is about to be entered, so every pin leaves a flop.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rst_cnt_d    = rst_cnt_q;
      hold_d       = hold_q;
      data_d       = data_q;
      frame_done_d = 1'b0;
      err_short_d  = 1'b0;
      err_drop_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (s_if.s_sof) begin
                  hold_d    = s_if.s_data;
                  rst_cnt_d = 4'(WRST_WCK - 1);
                  state_d   = RST_LO;
               end else begin
                  err_drop_d = 1'b1;
               end
            end
         end
         RST_LO: state_d = RST_HI;
         RST_HI: begin
            if (rst_cnt_q == 4'd0) begin
               data_d  = hold_q;
               state_d = WR_HOLD;
            end else begin
               rst_cnt_d = rst_cnt_q - 4'd1;
               state_d   = RST_LO;
            end
         end
         WR_HOLD: state_d = HI;
         LO: begin
            if (xfer) begin
               if (s_if.s_sof) begin
                  err_short_d = 1'b1;
                  hold_d      = s_if.s_data;
                  rst_cnt_d   = 4'(WRST_WCK - 1);
                  cnt_d       = '0;
                  state_d     = RST_LO;
               end else begin
                  data_d  = s_if.s_data;
                  state_d = HI;
               end
            end
         end
         HI: begin
            if ((cnt_q + CNT_W'(1)) == CNT_W'(FRAME_BYTES)) begin
               frame_done_d = 1'b1;
               cnt_d        = '0;
               state_d      = IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = LO;
            end
         end
         default: state_d = IDLE;
      endcase
      s_ready_d = (state_d == IDLE) || (state_d == LO);
      wck_d     = (state_d == RST_HI) || (state_d == HI);
      nwe_d     = !((state_d == WR_HOLD) || (state_d == HI));
      nwrst_d   = !((state_d == RST_LO) || (state_d == RST_HI));
   end

   // State and output registers. Reset takes effect at once, which also cuts
   // off a write clock that is already running.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rst_cnt_q    <= '0;
         hold_q       <= '0;
         data_q       <= '0;
         s_ready_q    <= 1'b0;
         wck_q        <= 1'b0;
         nwe_q        <= 1'b1;
         nwrst_q      <= 1'b1;
         frame_done_q <= 1'b0;
         err_short_q  <= 1'b0;
         err_drop_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rst_cnt_q    <= rst_cnt_d;
         hold_q       <= hold_d;
         data_q       <= data_d;
         s_ready_q    <= s_ready_d;
         wck_q        <= wck_d;
         nwe_q        <= nwe_d;
         nwrst_q      <= nwrst_d;
         frame_done_q <= frame_done_d;
         err_short_q  <= err_short_d;
         err_drop_q   <= err_drop_d;
      end
   end

   assign s_if.s_ready = s_ready_q;
   assign al422_data   = data_q;
   assign al422_wck    = wck_q;
   assign al422_nwe    = nwe_q;
   assign al422_nwrst  = nwrst_q;
   assign frame_done   = frame_done_q;
   assign err_short    = err_short_q;
   assign err_drop     = err_drop_q;

endmodule

// File: tb/tb_al422_writer.sv
// Directed bench for al422_writer with default parameters (256 bytes, 4 WCK
// pointer-reset periods). A monitor records every rising edge of WCK and every
// pulse. The test tasks compare those records with values worked out by hand.
module tb_al422_writer;

   logic       clk;
   logic       rst;
   logic [7:0] al422_data;
   logic       al422_wck, al422_nwe, al422_nwrst;
   logic       frame_done, err_short, err_drop;

   al422_writer_if sif ();

   al422_writer dut (
      .in_clk      (clk),
      .in_rst      (rst),
      .s_if        (sif),
      .al422_data  (al422_data),
      .al422_wck   (al422_wck),
      .al422_nwe   (al422_nwe),
      .al422_nwrst (al422_nwrst),
      .frame_done  (frame_done),
      .err_short   (err_short),
      .err_drop    (err_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor state
   int         cyc = 0;
   int         rst_rises, spur, fd_cnt, es_cnt, ed_cnt, nwe_low, overlap;
   logic [7:0] wq[$];
   int         wcyc[$];
   int         wrst[$];
   logic       pw = 1'b0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (al422_wck && !pw) begin
         if (!al422_nwrst) begin
            rst_rises++;
            if (!al422_nwe) spur++;
         end else if (al422_nwe) begin
            spur++;
         end else begin
            wq.push_back(al422_data);
            wcyc.push_back(cyc);
            wrst.push_back(rst_rises);
         end
      end
      pw = al422_wck;
      if (frame_done) fd_cnt++;
      if (err_short) es_cnt++;
      if (err_drop) ed_cnt++;
      if (!al422_nwe) nwe_low++;
      if (frame_done && (err_short || err_drop)) overlap++;
   end

   task automatic clear_mon();
      rst_rises = 0; spur = 0; fd_cnt = 0; es_cnt = 0; ed_cnt = 0;
      nwe_low = 0; overlap = 0;
      wq.delete(); wcyc.delete(); wrst.delete();
   endtask

   function automatic logic [7:0] exp_byte(input int i, input int base);
      return 8'((i * 7 + base) & 8'hff);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte and hold it until it is accepted. With gaps set, up to
   // three idle cycles may come first (about half the time).
   task automatic send(input logic [7:0] d, input logic sof, input bit gaps);
      int   budget;
      logic rdy;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         sif.s_valid = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
      end
      sif.s_data  = d;
      sif.s_sof   = sof;
      sif.s_valid = 1'b1;
      budget      = 0;
      do begin
         rdy = sif.s_ready;
         tick();
         budget++;
      end while (!rdy && budget < 50);
      if (!rdy) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: byte %h not accepted within 50 cycles", d);
      end
   endtask

   task automatic send_frame(input int base, input bit gaps);
      for (int i = 0; i < 256; i++) send(exp_byte(i, base), i == 0, gaps);
      sif.s_valid = 1'b0;
      sif.s_sof   = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (fd_cnt == 0 && k < 40) begin tick(); k++; end
      repeat (3) tick();
   endtask

   task automatic check_frame(input string nm, input int base, input bit timing);
      int bad = 0;
      n_checks++;
      if (wq.size() !== 256) begin
         n_fail++; $display("FAIL %s_count: got %0d writes, want 256", nm, wq.size());
      end
      n_checks++;
      if (rst_rises !== 4) begin
         n_fail++; $display("FAIL %s_wrst: got %0d WCK rises with nwrst low, want 4", nm, rst_rises);
      end
      if (wq.size() == 256) begin
         for (int i = 0; i < 256; i++) if (wq[i] !== exp_byte(i, base)) bad++;
         n_checks++;
         if (bad != 0) begin
            n_fail++; $display("FAIL %s_data: got %0d bytes out of order or wrong, want 0", nm, bad);
         end
         if (timing) begin
            n_checks++;
            if (wcyc[255] - wcyc[0] !== 510) begin
               n_fail++; $display("FAIL %s_rate: got %0d cycles for 255 byte steps, want 510", nm, wcyc[255] - wcyc[0]);
            end
         end
      end
      n_checks++;
      if (fd_cnt !== 1) begin
         n_fail++; $display("FAIL %s_done: got %0d frame_done cycles, want 1", nm, fd_cnt);
      end
      n_checks++;
      if (es_cnt + ed_cnt + spur + overlap !== 0) begin
         n_fail++; $display("FAIL %s_clean: got short=%0d drop=%0d spurious=%0d overlap=%0d, want all 0",
                            nm, es_cnt, ed_cnt, spur, overlap);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sif.s_data = 8'h00; sif.s_sof = 1'b0; sif.s_valid = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({sif.s_ready, al422_wck, al422_nwe, al422_nwrst} !== 4'b0011) begin
         n_fail++; $display("FAIL reset_ctrl: got rdy/wck/nwe/nwrst=%b, want 0011",
                            {sif.s_ready, al422_wck, al422_nwe, al422_nwrst});
      end
      n_checks++;
      if (al422_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: got %h, want 00", al422_data);
      end
      n_checks++;
      if ({frame_done, err_short, err_drop} !== 3'b000) begin
         n_fail++; $display("FAIL reset_pulses: got %b, want 000", {frame_done, err_short, err_drop});
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if ({sif.s_ready, al422_wck, al422_nwe, al422_nwrst} !== 4'b1011) begin
         n_fail++; $display("FAIL reset_release: got rdy/wck/nwe/nwrst=%b, want 1011",
                            {sif.s_ready, al422_wck, al422_nwe, al422_nwrst});
      end
   endtask

   task automatic test_full_frame();
      clear_mon();
      send_frame(3, 1'b0);
      wait_done();
      check_frame("full", 3, 1'b1);
   endtask

   task automatic test_drop();
      clear_mon();
      for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 1'b0, 1'b0);
      sif.s_valid = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (ed_cnt !== 3) begin
         n_fail++; $display("FAIL drop_count: got %0d err_drop cycles, want 3", ed_cnt);
      end
      n_checks++;
      if (rst_rises + wq.size() + spur + nwe_low !== 0) begin
         n_fail++; $display("FAIL drop_quiet: got rises=%0d writes=%0d nwe_low=%0d, want 0",
                            rst_rises + spur, wq.size(), nwe_low);
      end
      n_checks++;
      if (sif.s_ready !== 1'b1) begin
         n_fail++; $display("FAIL drop_ready: got %b, want 1", sif.s_ready);
      end
   endtask

   task automatic test_gaps();
      bit stall_ok = 1'b1;
      clear_mon();
      for (int i = 0; i < 256; i++) begin
         send(exp_byte(i, 11), i == 0, 1'b1);
         if (i == 50) begin
            sif.s_valid = 1'b0;
            tick();
            repeat (10) begin
               tick();
               if (al422_wck !== 1'b0 || al422_nwe !== 1'b1) stall_ok = 1'b0;
            end
         end
      end
      sif.s_valid = 1'b0;
      sif.s_sof   = 1'b0;
      wait_done();
      n_checks++;
      if (!stall_ok) begin
         n_fail++; $display("FAIL gaps_stall: got WCK or nwe activity during LO stall, want wck=0 nwe=1");
      end
      check_frame("gaps", 11, 1'b0);
   endtask

   task automatic test_short();
      clear_mon();
      send(8'hA0, 1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) send(8'hA0 + 8'(i), 1'b0, 1'b0);
      send(8'hC3, 1'b1, 1'b0);
      sif.s_valid = 1'b0;
      sif.s_sof   = 1'b0;
      repeat (20) tick();
      n_checks++;
      if (es_cnt !== 1) begin
         n_fail++; $display("FAIL short_err: got %0d err_short cycles, want 1", es_cnt);
      end
      n_checks++;
      if (rst_rises !== 8) begin
         n_fail++; $display("FAIL short_wrst: got %0d WCK rises with nwrst low, want 8", rst_rises);
      end
      n_checks++;
      if (wq.size() !== 12) begin
         n_fail++; $display("FAIL short_count: got %0d writes, want 12", wq.size());
      end else begin
         n_checks++;
         if (wq[10] !== 8'hAA || wq[11] !== 8'hC3 || wrst[11] !== 8) begin
            n_fail++; $display("FAIL short_order: got last=%h prev=%h rst_before=%0d, want C3 AA 8",
                               wq[11], wq[10], wrst[11]);
         end
      end
      n_checks++;
      if (fd_cnt + spur !== 0) begin
         n_fail++; $display("FAIL short_clean: got done=%0d spurious=%0d, want 0", fd_cnt, spur);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      clear_mon();
      for (int i = 0; i <= 100; i++) send(exp_byte(i, 5), i == 0, 1'b0);
      sif.s_valid = 1'b0;
      n_checks++;
      if (al422_wck !== 1'b1) begin
         n_fail++; $display("FAIL mid_in_hi: got wck=%b after byte 100, want 1", al422_wck);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({sif.s_ready, al422_wck, al422_nwe, al422_nwrst, al422_data} !== {4'b0011, 8'h00}) begin
         n_fail++; $display("FAIL mid_reset_now: got rdy/wck/nwe/nwrst=%b data=%h, want 0011 00",
                            {sif.s_ready, al422_wck, al422_nwe, al422_nwrst}, al422_data);
      end
      repeat (3) tick();
      n_checks++;
      if (wq.size() !== 101 || spur !== 0) begin
         n_fail++; $display("FAIL mid_abort: got %0d writes spurious=%0d, want 101 0", wq.size(), spur);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (sif.s_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_release: got rdy=%b, want 1", sif.s_ready);
      end
      clear_mon();
      send_frame(9, 1'b0);
      wait_done();
      check_frame("restart", 9, 1'b1);
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_drop();
      test_gaps();
      test_short();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
